// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: format select
// encodings and the record held in each pipeline slot.
package imm_pkg;

    localparam logic [2:0] IMM_R     = 3'd0;
    localparam logic [2:0] IMM_S     = 3'd1;
    localparam logic [2:0] IMM_B     = 3'd2;
    localparam logic [2:0] IMM_U     = 3'd3;
    localparam logic [2:0] IMM_J     = 3'd4;
    localparam logic [2:0] IMM_I     = 3'd5;
    localparam logic [2:0] IMM_SHAMT = 3'd6;
    localparam logic [2:0] IMM_ZIMM  = 3'd7;

    // Slot fields are sized for the widest legal configuration (XLEN=64,
    // tags up to 16 bits); narrower instances leave the upper bits unused.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [IMM_MAX_W-1:0] imm;
        logic [TAG_MAX_W-1:0] tag;
        logic                 illegal;
    } imm_slot_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: extracts the immediate for the
// selected format and extends it to XLEN bits.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // The opcode bits never contribute to any immediate.
    logic [6:0] unused_opcode;
    assign unused_opcode = inst[6:0];

    // Format mux; size casts of signed operands sign-extend, unsigned zero-extend.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_sel)
            IMM_R:     imm = '0;
            IMM_S:     imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            IMM_B:     imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            IMM_U:     imm = XLEN'($signed({inst[31:12], 12'b0}));
            IMM_J:     imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            IMM_I:     imm = XLEN'($signed(inst[31:20]));
            IMM_SHAMT: begin
                if (XLEN == 64) begin
                    imm = XLEN'(inst[25:20]);
                end else begin
                    imm     = XLEN'(inst[24:20]);
                    illegal = inst[25];
                end
            end
            IMM_ZIMM:  imm = XLEN'(inst[19:15]);
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes at the input, then carries the
// immediate, tag and illegal flag through STAGES valid/ready slots.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int LAST = STAGES - 1;

    logic [XLEN-1:0]   dec_imm;
    logic              dec_illegal;
    imm_slot_t         slot_q [STAGES];
    imm_slot_t         src    [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] accept;
    logic              unused_pad;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst    (inst),
        .imm_sel (imm_sel),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // Gather the slot valid bits into one vector for the acceptance logic.
    always_comb begin
        valid_q = '0;
        for (int i = 0; i < STAGES; i++) begin
            valid_q[i] = slot_q[i].valid;
        end
    end

    // A slot can take new data unless it and every slot ahead of it are full
    // with the output stalled; written without a bit-to-bit chain.
    always_comb begin
        logic full_ahead;
        accept     = '0;
        full_ahead = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            full_ahead = 1'b1;
            for (int j = i; j < STAGES; j++) begin
                full_ahead = full_ahead & valid_q[j];
            end
            accept[i] = !full_ahead || out_ready;
        end
    end

    // Source of each slot: the freshly decoded entry for slot 0, the
    // previous slot otherwise.
    always_comb begin
        src[0]         = '0;
        src[0].valid   = in_valid;
        src[0].imm     = IMM_MAX_W'(dec_imm);
        src[0].tag     = TAG_MAX_W'(in_tag);
        src[0].illegal = dec_illegal;
        for (int i = 1; i < STAGES; i++) begin
            src[i] = slot_q[i-1];
        end
    end

    // Slot registers: async clear, flush drops all entries, otherwise each
    // accepting slot takes its source and keeps stale data when it empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                slot_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                slot_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (accept[i]) begin
                    slot_q[i].valid <= src[i].valid;
                    if (src[i].valid) begin
                        slot_q[i].imm     <= src[i].imm;
                        slot_q[i].tag     <= src[i].tag;
                        slot_q[i].illegal <= src[i].illegal;
                    end
                end
            end
        end
    end

    assign in_ready    = accept[0];
    assign out_valid   = slot_q[LAST].valid;
    assign out_imm     = slot_q[LAST].imm[XLEN-1:0];
    assign out_tag     = slot_q[LAST].tag[TAG_W-1:0];
    assign out_illegal = slot_q[LAST].illegal;

    // Padding bits of the widest-case record that this instance never reads.
    assign unused_pad = ^{slot_q[LAST].imm, slot_q[LAST].tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: three instances (32-bit/1 stage,
// 64-bit/2 stages, 32-bit/3 stages) share one stimulus stream and are each
// compared against a queue-based reference model.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    localparam int TAG_W = 5;
    localparam int NDUT  = 3;
    localparam int QDEP  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      inst = '0;
    logic [2:0]       imm_sel = '0;
    logic [TAG_W-1:0] in_tag = '0;

    logic rdy_a, vld_a, ill_a; logic [31:0] imm_a; logic [TAG_W-1:0] tag_a;
    logic rdy_b, vld_b, ill_b; logic [63:0] imm_b; logic [TAG_W-1:0] tag_b;
    logic rdy_c, vld_c, ill_c; logic [31:0] imm_c; logic [TAG_W-1:0] tag_c;

    imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(TAG_W)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(vld_a),
        .out_ready(out_ready), .out_imm(imm_a), .out_tag(tag_a), .out_illegal(ill_a));

    imm_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(TAG_W)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(vld_b),
        .out_ready(out_ready), .out_imm(imm_b), .out_tag(tag_b), .out_illegal(ill_b));

    imm_gen_pipe #(.XLEN(32), .STAGES(3), .TAG_W(TAG_W)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(vld_c),
        .out_ready(out_ready), .out_imm(imm_c), .out_tag(tag_c), .out_illegal(ill_c));

    logic             obs_ready [NDUT];
    logic             obs_valid [NDUT];
    logic [63:0]      obs_imm   [NDUT];
    logic [TAG_W-1:0] obs_tag   [NDUT];
    logic             obs_ill   [NDUT];

    // Collect the three instances' outputs into indexable arrays.
    always_comb begin
        obs_ready[0] = rdy_a; obs_valid[0] = vld_a; obs_imm[0] = {32'h0, imm_a};
        obs_tag[0]   = tag_a; obs_ill[0]   = ill_a;
        obs_ready[1] = rdy_b; obs_valid[1] = vld_b; obs_imm[1] = imm_b;
        obs_tag[1]   = tag_b; obs_ill[1]   = ill_b;
        obs_ready[2] = rdy_c; obs_valid[2] = vld_c; obs_imm[2] = {32'h0, imm_c};
        obs_tag[2]   = tag_c; obs_ill[2]   = ill_c;
    end

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
        int               acc;
    } entry_t;

    entry_t mq [NDUT][QDEP];
    int     mhead [NDUT];
    int     mcnt  [NDUT];
    int     mlast_pop [NDUT];
    int     cyc;
    logic   exp_v [NDUT];
    logic   exp_r [NDUT];

    logic             snap_ready [NDUT];
    logic             snap_valid [NDUT];
    logic [TAG_W-1:0] snap_tag   [NDUT];

    int   checks = 0;
    int   failures = 0;
    logic log_en = 1'b0;
    int   exit_cnt = 0;
    logic [TAG_W-1:0] exit_tags [16];

    function automatic int stages_of(input int d);
        return d + 1;
    endfunction

    function automatic int xlen_of(input int d);
        return (d == 1) ? 64 : 32;
    endfunction

    function automatic longint sext_field(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (v >= half) ? v - 2 * half : v;
    endfunction

    function automatic logic [63:0] ref_imm(input int xlen, input logic [31:0] w, input logic [2:0] sel);
        longint v;
        case (sel)
            IMM_R:     v = 0;
            IMM_S:     v = sext_field(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
            IMM_B:     v = sext_field(longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                                      + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
            IMM_U:     v = sext_field(longint'(w[31:12]) * 4096, 32);
            IMM_J:     v = sext_field(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                                      + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
            IMM_I:     v = sext_field(longint'(w[31:20]), 12);
            IMM_SHAMT: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default:   v = longint'(w[19:15]);
        endcase
        if (xlen == 32) return 64'(v) & 64'h0000_0000_FFFF_FFFF;
        return 64'(v);
    endfunction

    function automatic logic ref_ill(input int xlen, input logic [31:0] w, input logic [2:0] sel);
        return (sel == IMM_SHAMT) && (xlen == 32) && w[25];
    endfunction

    // An entry is visible once it has travelled STAGES-1 edges and its
    // predecessor has left the output.
    function automatic logic model_valid(input int d);
        int arrive;
        if (mcnt[d] == 0) return 1'b0;
        arrive = mq[d][mhead[d]].acc + stages_of(d) - 1;
        if (mlast_pop[d] > arrive) arrive = mlast_pop[d];
        return arrive <= cyc;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            mhead[d] = 0; mcnt[d] = 0; mlast_pop[d] = 0;
        end
        cyc = 0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model on the rising edge.
    task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [31:0] w,
                                 input logic [TAG_W-1:0] tg, input logic ordy, input logic fl);
        int idx;
        @(negedge clk);
        in_valid = v; imm_sel = sel; inst = w; in_tag = tg; out_ready = ordy; flush = fl;
        #2;
        for (int d = 0; d < NDUT; d++) begin
            exp_v[d] = model_valid(d);
            exp_r[d] = (mcnt[d] < stages_of(d)) || (exp_v[d] && out_ready);
            snap_ready[d] = obs_ready[d];
            snap_valid[d] = obs_valid[d];
            snap_tag[d]   = obs_tag[d];
            checkOutput($sformatf("in_ready[%0d]", d), obs_ready[d], exp_r[d]);
            checkOutput($sformatf("out_valid[%0d]", d), obs_valid[d], exp_v[d]);
            if (exp_v[d]) begin
                checkOutput($sformatf("out_imm[%0d]", d), obs_imm[d], mq[d][mhead[d]].imm);
                checkOutput($sformatf("out_tag[%0d]", d), obs_tag[d], mq[d][mhead[d]].tag);
                checkOutput($sformatf("out_illegal[%0d]", d), obs_ill[d], mq[d][mhead[d]].ill);
            end
        end
        if (log_en && obs_valid[2] && out_ready && exit_cnt < 16) begin
            exit_tags[exit_cnt] = obs_tag[2];
            exit_cnt++;
        end
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            if (fl) begin
                mhead[d] = 0; mcnt[d] = 0; mlast_pop[d] = 0;
            end else begin
                if (exp_v[d] && ordy) begin
                    mhead[d] = (mhead[d] + 1) % QDEP;
                    mcnt[d]--;
                    mlast_pop[d] = cyc + 1;
                end
                if (v && exp_r[d]) begin
                    idx = (mhead[d] + mcnt[d]) % QDEP;
                    mq[d][idx] = '{ref_imm(xlen_of(d), w, sel), tg, ref_ill(xlen_of(d), w, sel), cyc + 1};
                    mcnt[d]++;
                end
            end
        end
        cyc++;
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must
    // clear before any edge arrives.
    task automatic resetPulse();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("rst_valid[%0d]", d), obs_valid[d], 64'h0);
            checkOutput($sformatf("rst_imm[%0d]", d), obs_imm[d], 64'h0);
            checkOutput($sformatf("rst_tag[%0d]", d), obs_tag[d], 64'h0);
            checkOutput($sformatf("rst_illegal[%0d]", d), obs_ill[d], 64'h0);
        end
        #3 rst_n = 1'b1;
        model_reset();
    endtask

    // Global time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence: directed scenarios followed by a randomized stream.
    initial begin
        int next_tag;
        logic [TAG_W-1:0] t;

        resetPulse();

        // Single-stage 32-bit decodes with the output always ready.
        applyStimulus(1'b1, IMM_I, 32'hFFF00093, 5'd1, 1'b1, 1'b0);
        #1 checkOutput("t1_i_imm", {32'h0, imm_a}, 64'hFFFF_FFFF);
        checkOutput("t1_i_valid", vld_a, 1'b1);
        applyStimulus(1'b1, IMM_B, 32'hFE000E63, 5'd2, 1'b1, 1'b0);
        #1 checkOutput("t1_b_imm", {32'h0, imm_a}, 64'hFFFF_F7FC);
        applyStimulus(1'b1, IMM_B, 32'hFE000EE3, 5'd3, 1'b1, 1'b0);
        #1 checkOutput("t1_b2_imm", {32'h0, imm_a}, 64'hFFFF_FFFC);

        // 64-bit U and SHAMT on the two-stage instance.
        applyStimulus(1'b1, IMM_U, 32'h800002B7, 5'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, IMM_SHAMT, 32'h03F00013, 5'd5, 1'b1, 1'b0);
        #1 checkOutput("t2_u_imm", imm_b, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(1'b1, IMM_SHAMT, 32'h02300013, 5'd6, 1'b1, 1'b0);
        #1 checkOutput("t2_shamt_imm", imm_b, 64'd63);
        checkOutput("t2_shamt_ill", ill_b, 1'b0);
        checkOutput("t3_shamt_ill", ill_a, 1'b1);
        checkOutput("t3_shamt_imm", {32'h0, imm_a}, 64'd3);
        applyStimulus(1'b1, IMM_ZIMM, 32'h000F8073, 5'd7, 1'b1, 1'b0);
        #1 checkOutput("t3_zimm_imm", {32'h0, imm_a}, 64'h1F);

        // Stall on the three-stage instance: six tags, output blocked for cycles 2..6.
        applyStimulus(1'b0, IMM_R, 32'h0, 5'd0, 1'b1, 1'b1);
        next_tag = 0;
        log_en = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            t = TAG_W'(next_tag);
            applyStimulus(next_tag < 6, 3'(next_tag), 32'hA5C3_0F00 + 32'h0101_0101 * next_tag,
                          t, !(c >= 2 && c <= 6), 1'b0);
            if (c == 3) checkOutput("t4_ready_before_full", snap_ready[2], 1'b1);
            if (c == 4) checkOutput("t4_ready_low", snap_ready[2], 1'b0);
            if (c >= 4 && c <= 6) begin
                checkOutput($sformatf("t4_hold_valid_c%0d", c), snap_valid[2], 1'b1);
                checkOutput($sformatf("t4_hold_tag_c%0d", c), snap_tag[2], 64'd0);
            end
            if (next_tag < 6 && exp_r[2]) next_tag++;
        end
        log_en = 1'b0;
        checkOutput("t4_exit_count", exit_cnt, 64'd6);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("t4_exit_order%0d", k), exit_tags[k], k);
        end

        // Flush with a full two-stage chain and a simultaneous input entry.
        applyStimulus(1'b1, IMM_I, 32'h00A00093, 5'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, IMM_I, 32'h00B00093, 5'd11, 1'b0, 1'b0);
        applyStimulus(1'b1, IMM_I, 32'h00C00093, 5'd12, 1'b0, 1'b0);
        applyStimulus(1'b1, IMM_I, 32'h01E00093, 5'h1E, 1'b0, 1'b1);
        checkOutput("t5_full_before", snap_valid[1], 1'b1);
        #1 checkOutput("t5_flushed_b", vld_b, 1'b0);
        checkOutput("t5_flushed_c", vld_c, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, IMM_R, 32'h0, 5'd0, 1'b1, 1'b0);
            checkOutput($sformatf("t5_no_ghost%0d", c), snap_valid[1], 1'b0);
        end

        // Mid-stream asynchronous reset, then first-entry latency.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, IMM_J, $urandom, TAG_W'(c + 20), 1'b1, 1'b0);
        end
        resetPulse();
        applyStimulus(1'b1, IMM_I, 32'h12300093, 5'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, IMM_R, 32'h0, 5'd0, 1'b1, 1'b0);
        checkOutput("t6_lat_s1", snap_valid[0], 1'b1);
        checkOutput("t6_early_s3_a", snap_valid[2], 1'b0);
        applyStimulus(1'b0, IMM_R, 32'h0, 5'd0, 1'b1, 1'b0);
        checkOutput("t6_lat_s2", snap_valid[1], 1'b1);
        checkOutput("t6_early_s3_b", snap_valid[2], 1'b0);
        applyStimulus(1'b0, IMM_R, 32'h0, 5'd0, 1'b1, 1'b0);
        checkOutput("t6_lat_s3", snap_valid[2], 1'b1);
        checkOutput("t6_lat_s3_tag", snap_tag[2], 64'd7);

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
                          TAG_W'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 31) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
